// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock, start/ready/done handshake.
// Optional leading-zero mask output `blank` is built when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq #(
  parameter int IN_W   = 14,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Each digit >= 5 gets +3 independently so that the following shift carries correctly.
  function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] w);
    logic [BCD_W-1:0] r;
    r = w;
    for (int k = 0; k < DIGITS; k++) begin
      if (w[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = w[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = w[4*k +: 4];
      end
    end
    return r;
  endfunction

`ifdef BIN2BCD_BLANK_EN
  // Bit k set when digit k and every higher digit are zero; units digit never blanked.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [BCD_W-1:0] w);
    logic [DIGITS-1:0] m;
    logic              z;
    z = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      z    = z & (w[4*k +: 4] == 4'd0);
      m[k] = z;
    end
    m[0] = 1'b0;
    return m;
  endfunction
`endif

  state_t             state_q, state_d;
  logic [IN_W-1:0]    sh_q, sh_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   adj_work;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_w_q, ovf_w_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0]  blank_q, blank_d;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      ovf_w_q <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      ovf_w_q <= ovf_w_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef BIN2BCD_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  // Next-state logic; the last CONV cycle is the one where cnt reaches IN_W-1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        if (cnt_q == CNT_W'(IN_W - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CONV;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output register inputs; ready/busy are registered from the next state.
  always_comb begin
    adj_work = add3_adjust(work_q);
    sh_d     = sh_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    ovf_w_d  = ovf_w_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    ready_d  = (state_d == S_IDLE);
    busy_d   = (state_d == S_CONV) || (state_d == S_DONE);
`ifdef BIN2BCD_BLANK_EN
    blank_d  = blank_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d    = in;
          work_d  = '0;
          cnt_d   = '0;
          ovf_w_d = 1'b0;
        end else begin
          sh_d    = sh_q;
          work_d  = work_q;
        end
      end
      S_CONV: begin
        work_d = {adj_work[BCD_W-2:0], sh_q[IN_W-1]};
        sh_d   = {sh_q[IN_W-2:0], 1'b0};
        cnt_d  = cnt_q + CNT_W'(1);
        // A set MSB after adjust is a carry out of the top digit, i.e. weight 10^DIGITS lost.
        if (adj_work[BCD_W-1]) begin
          ovf_w_d = 1'b1;
        end else begin
          ovf_w_d = ovf_w_q;
        end
      end
      S_DONE: begin
        bcd_d  = work_q;
        ovf_d  = ovf_w_q;
        done_d = 1'b1;
`ifdef BIN2BCD_BLANK_EN
        blank_d = lz_mask(work_q);
`endif
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign ovf   = ovf_q;
`ifdef BIN2BCD_BLANK_EN
  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 5-digit and a 4-digit instance share stimulus and are
// checked against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] in_v = 14'd0;
  logic        ready5, busy5, done5, ovf5;
  logic        ready4, busy4, done4, ovf4;
  logic [19:0] bcd5;
  logic [15:0] bcd4;
`ifdef BIN2BCD_BLANK_EN
  logic [4:0]  blank5;
  logic [3:0]  blank4;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  typedef struct {
    logic [19:0] bcd5;
    logic        ovf5;
    logic [15:0] bcd4;
    logic        ovf4;
    logic [4:0]  bl5;
    logic [3:0]  bl4;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t hold;

  bin2bcd_seq #(.IN_W(14), .DIGITS(5)) u_dut5 (
    .clk(clk), .reset(reset), .start(start), .in(in_v),
    .ready(ready5), .busy(busy5), .done(done5), .bcd(bcd5), .ovf(ovf5)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank5)
`endif
  );

  bin2bcd_seq #(.IN_W(14), .DIGITS(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .in(in_v),
    .ready(ready4), .busy(busy4), .done(done4), .bcd(bcd4), .ovf(ovf4)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank4)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [19:0] to_bcd(input int x);
    logic [19:0] r;
    int          t;
    r = 20'd0;
    t = x;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Leading-zero mask from the value: digit k and above are zero iff the value is below 10^k.
  function automatic logic [4:0] blank_model(input int v, input int digits);
    logic [4:0] m;
    int         r;
    m = 5'd0;
    r = v % pow10(digits);
    for (int k = 1; k < digits; k++) m[k] = (r < pow10(k));
    return m;
  endfunction

  function automatic exp_t model(input int v, input int acc);
    exp_t e;
    e.bcd5 = to_bcd(v % 100000);
    e.ovf5 = (v >= 100000);
    e.bcd4 = 16'(to_bcd(v % 10000));
    e.ovf4 = (v >= 10000);
    e.bl5  = blank_model(v, 5);
    e.bl4  = 4'(blank_model(v, 4));
    e.acc  = acc;
    return e;
  endfunction

  // Raises start with the value, waits until it is accepted, then drops start.
  task automatic issue(input int v);
    int guard;
    guard = 0;
    @(negedge clk);
    start = 1'b1;
    in_v  = 14'(v);
    while (!ready5 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      chk("accept_timeout", 64'(guard), 64'd0);
      start = 1'b0;
    end else begin
      exp_q.push_back(model(v, cyc + 1));
      @(negedge clk);
      chk("ready_drop", {62'd0, ready5, ready4}, 64'd0);
      chk("busy_rise", {62'd0, busy5, busy4}, 64'd3);
      start = 1'b0;
      in_v  = 14'(v ^ 14'h2aaa);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // Monitor: pops on every done, otherwise verifies outputs hold the last result.
  always @(negedge clk) begin
    exp_t e;
    if (done5 || done4) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", {62'd0, done5, done4}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_both", {62'd0, done5, done4}, 64'd3);
        chk("bcd5", 64'(bcd5), 64'(e.bcd5));
        chk("ovf5", 64'(ovf5), 64'(e.ovf5));
        chk("bcd4", 64'(bcd4), 64'(e.bcd4));
        chk("ovf4", 64'(ovf4), 64'(e.ovf4));
        chk("latency", 64'(cyc - e.acc), 64'd15);
`ifdef BIN2BCD_BLANK_EN
        chk("blank5", 64'(blank5), 64'(e.bl5));
        chk("blank4", 64'(blank4), 64'(e.bl4));
`endif
        hold = e;
      end
    end else begin
      chk("hold", {23'd0, bcd5, ovf5, bcd4, ovf4, ready5 ^ busy5},
          {23'd0, hold.bcd5, hold.ovf5, hold.bcd4, hold.ovf4, 1'b1});
    end
  end

  initial begin
    int v;
    hold = model(0, 0);
    hold.bl5 = 5'd0;
    hold.bl4 = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset_state", {42'd0, bcd5, ovf5, done5, ready5, busy5},
        {42'd0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    reset = 1'b0;
    @(negedge clk);

    issue(16383);
    drain();

    issue(0);
    issue(9999);
    drain();

    // A start pulse during conversion must be ignored.
    issue(1234);
    repeat (3) @(negedge clk);
    start = 1'b1;
    in_v  = 14'd5;
    @(negedge clk);
    start = 1'b0;
    drain();

    issue(12345);
    issue(9999);
    drain();

    // Asynchronous reset mid-conversion aborts with no done pulse.
    issue(3000);
    repeat (6) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    hold = model(0, 0);
    hold.bl5 = 5'd0;
    hold.bl4 = 4'd0;
    chk("async_reset", {40'd0, bcd5, ovf5, done5, ready5, busy5, done4, ready4},
        {40'd0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {62'd0, ready5, ready4}, 64'd3);

    issue(42);
    drain();
    issue(0);
    drain();
    issue(16383);
    drain();

    for (int i = 0; i < 25; i++) begin
      v = $urandom_range(0, 16383);
      issue(v);
      if ((i % 3) == 0) drain();
    end
    drain();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm. It processes one input bit per clock, with the add-3 adjust and the shift merged into a single cycle. It has a start/ready/done handshake, configurable input width and digit count, and an overflow flag. It feeds score/timer digit displays and the seven-segment driver.

Parameters:
IN_W, 14, binary input width in bits (>= 2).
DIGITS, 5, number of BCD output digits (>= 1); output width is 4*DIGITS.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a conversion; accepted only when ready=1
in  input  IN_W  unsigned binary value, sampled on the accepting edge
ready  output  1  high in IDLE; converter can accept start
busy  output  1  high while a conversion is in progress (CONV or DONE)
done  output  1  one-cycle pulse; bcd/ovf valid and updated on the same edge
bcd  output  4*DIGITS  result; digit k = bcd[4k+3:4k], digit 0 = units; held until the next done
ovf  output  1  value did not fit in DIGITS digits; held with bcd
blank  output  DIGITS  leading-zero mask; present only with BIN2BCD_BLANK_EN

Behaviour:
- Reset is asynchronous, active-high, on clock clk. It forces state=IDLE and clears the work register, shift register, count, bcd, ovf, done and blank to 0. Then ready=1 and busy=0.
- Registers:
  - sh: IN_W-bit shift register.
  - work: 4*DIGITS-bit BCD accumulator.
  - cnt: clog2(IN_W+1) bits.
  - ovf_w: sticky overflow flag.
- IDLE:
  - ready=1.
  - If start=1: sh<=in, work<=0, cnt<=0, ovf_w<=0, go to CONV.
- CONV, each cycle:
  1. Adjust: every digit of work that is >= 5 gets +3 (4-bit add, no inter-digit carry).
  2. Shift: work <= {adjusted[4*DIGITS-2:0], sh[IN_W-1]} and sh <= sh<<1.
  3. If bit adjusted[4*DIGITS-1] is 1, set ovf_w.
  4. cnt<=cnt+1. When cnt==IN_W-1 on this edge, go to DONE.
  - This gives exactly IN_W CONV cycles.
- DONE:
  - bcd<=work, ovf<=ovf_w, done<=1 for exactly one cycle, go to IDLE.
  - done is registered and deasserts on the following edge.
- Latency:
  - start is accepted at edge 0.
  - bcd, ovf and done update at edge IN_W+1.
  - ready returns at edge IN_W+1.
  - Back-to-back throughput is one conversion per IN_W+1 cycles.
  - start held high in the done cycle is accepted (ready=1 then).
- While busy=1, start is ignored and in is not sampled. An in-flight conversion is never disturbed.
- The bcd/ovf outputs are unchanged from done until the next done. Intermediate work values are never visible on bcd.
- If ovf=1, bcd holds the value modulo 10^DIGITS.
- Reset during CONV or DONE aborts immediately: no done pulse, and outputs are cleared.
- in=0 yields all-zero bcd, ovf=0.
- in = all-ones is handled with no special case.

Optional Feature:
Macro BIN2BCD_BLANK_EN.
- Defined: adds output blank[DIGITS-1:0], registered and updated with bcd on done. Bit k=1 iff digit k and all higher digits are zero. Bit 0 is always 0, so the units digit always shows. Reset value is 0.
- Undefined: the blank port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, reset released, in=16383 pulsed with start -> ready drops next cycle; done high exactly 15 cycles after accept; bcd=0x16383; ovf=0.
- in=0 -> bcd=0x00000, ovf=0, done after 15 cycles. Then in=9999 back-to-back (start held through done cycle) -> bcd=0x09999.
- start pulsed with in=5 mid-conversion of in=1234 -> ignored; result 0x01234; exactly one done pulse.
- DIGITS=4, IN_W=14, in=12345 -> ovf=1, bcd=0x2345. Then in=9999 -> ovf=0, bcd=0x9999.
- reset asserted at cycle 7 of a conversion -> outputs cleared asynchronously, no done pulse, ready=1 after release. A new conversion of 42 -> bcd=0x00042.
- BIN2BCD_BLANK_EN defined:
  - in=42 -> blank=5'b11100.
  - in=0 -> blank=5'b11110.
  - in=16383 -> blank=5'b00000.
